// File: rtl/inst_fetch_dual_pkg.sv
// inst_fetch_dual_pkg: shared constants, state encoding and address helper for the fetch unit
package inst_fetch_dual_pkg;
    localparam logic VALID = 1'b1;
    localparam logic INVALID = 1'b0;
    localparam int INST_BUS_W = 32;
    localparam int INST_ADDR_W = 32;
    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;
    function automatic logic [INST_ADDR_W-1:0] align8(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:3], 3'b000};
    endfunction
endpackage

// File: rtl/inst_fetch_dual_fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register (reset / redirect / sequential +8) and its 8-byte aligned fetch address
//   ports: clk, rst, redirect, redirect_pc, advance (a response was delivered), pc, fetch_addr
module fetch_pc_gen
    import inst_fetch_dual_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [INST_ADDR_W-1:0] redirect_pc,
    input  logic                   advance,
    output logic [INST_ADDR_W-1:0] pc,
    output logic [INST_ADDR_W-1:0] fetch_addr
);
    assign fetch_addr = align8(pc);
    always_ff @(posedge clk)
        if (rst) pc <= RESET_PC;
        else if (redirect) pc <= redirect_pc;
        else if (advance) pc <= fetch_addr + 32'd8;
endmodule

// File: rtl/inst_fetch_dual.sv
// inst_fetch_dual: fetches 64-bit aligned pairs over an SRAM-like port and writes up to two instructions into the buffer
//   ports: clk/rst; redirect_i/redirect_pc_i flush; buffer_full_i backpressure; inst_sram_* fetch port;
//   inst1_*/inst2_* registered buffer write ports; pc_o debug PC;
//   stall_cnt_o/cancel_cnt_o saturating perf counters only when FETCH_PERF_CNT_EN is defined
module inst_fetch_dual
    import inst_fetch_dual_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int PERF_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_i,
    input  logic [INST_ADDR_W-1:0] redirect_pc_i,
    input  logic                   buffer_full_i,
    output logic                   inst_sram_req_o,
    output logic [INST_ADDR_W-1:0] inst_sram_addr_o,
    input  logic                   inst_sram_addr_ok_i,
    input  logic                   inst_sram_data_ok_i,
    input  logic [63:0]            inst_sram_rdata_i,
    output logic [INST_BUS_W-1:0]  inst1_o,
    output logic [INST_BUS_W-1:0]  inst2_o,
    output logic [INST_ADDR_W-1:0] inst1_addr_o,
    output logic [INST_ADDR_W-1:0] inst2_addr_o,
    output logic                   inst1_valid_o,
    output logic                   inst2_valid_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [PERF_W-1:0]      stall_cnt_o,
    output logic [PERF_W-1:0]      cancel_cnt_o,
`endif
    output logic [INST_ADDR_W-1:0] pc_o
);
    state_t state, state_n;
    logic cancel, cancel_n, req_hold, accept, resp, deliver, pair;
    logic [INST_ADDR_W-1:0] fetch_addr;
    fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk(clk), .rst(rst), .redirect(redirect_i), .redirect_pc(redirect_pc_i),
        .advance(deliver), .pc(pc_o), .fetch_addr(fetch_addr)
    );
    // buffer_full_i only gates raising a request; a raised one is held until addr_ok or redirect
    assign inst_sram_req_o = !rst && state == S_REQ && (req_hold || !buffer_full_i);
    assign inst_sram_addr_o = rst ? '0 : fetch_addr;
    assign accept = inst_sram_req_o && inst_sram_addr_ok_i;
    assign resp = state == S_WAIT && inst_sram_data_ok_i;
    assign deliver = resp && !cancel && !redirect_i;
    assign pair = !pc_o[2];
    always_comb begin
        state_n = (accept || (state == S_WAIT && !inst_sram_data_ok_i)) ? S_WAIT : S_REQ;
        // a redirect leaving a fetch in flight marks its response for discard
        cancel_n = redirect_i ? state_n == S_WAIT : (resp ? 1'b0 : cancel);
    end
    always_ff @(posedge clk)
        if (rst) begin
            state <= S_REQ;
            cancel <= 1'b0;
            req_hold <= 1'b0;
            inst1_valid_o <= INVALID;
            inst2_valid_o <= INVALID;
            inst1_o <= '0;
            inst2_o <= '0;
            inst1_addr_o <= '0;
            inst2_addr_o <= '0;
        end else begin
            state <= state_n;
            cancel <= cancel_n;
            req_hold <= inst_sram_req_o && !inst_sram_addr_ok_i && !redirect_i;
            inst1_valid_o <= deliver ? VALID : INVALID;
            inst2_valid_o <= deliver && pair ? VALID : INVALID;
            inst1_o <= deliver ? (pair ? inst_sram_rdata_i[31:0] : inst_sram_rdata_i[63:32]) : '0;
            inst1_addr_o <= deliver ? pc_o : '0;
            inst2_o <= deliver && pair ? inst_sram_rdata_i[63:32] : '0;
            inst2_addr_o <= deliver && pair ? pc_o + 32'd4 : '0;
        end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk)
        if (rst) begin
            stall_cnt_o <= '0;
            cancel_cnt_o <= '0;
        end else begin
            stall_cnt_o <= stall_cnt_o + PERF_W'(state == S_REQ && buffer_full_i && !(&stall_cnt_o));
            cancel_cnt_o <= cancel_cnt_o + PERF_W'(resp && (cancel || redirect_i) && !(&cancel_cnt_o));
        end
`endif
endmodule
